// File: rtl/dma_mon_pkg.sv
// Shared types and defaults for the DMA request/acknowledge monitor.
// Holds the per-channel state enum, default parameters and a popcount helper.
package dma_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } ch_state_t;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_MAX_WAIT = 16;
  localparam int MAX_CH       = 8;

  function automatic int unsigned popcount8(input logic [MAX_CH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dma_mon_channel.sv
// One monitored DMA channel: IDLE/REQ/ACK tracker, wait counter,
// saturating request/acknowledge counters and sticky per-channel error flags.
module dma_mon_channel
  import dma_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             dreq,
  input  logic             dack,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] ack_count,
  output logic             err_timeout,
  output logic             err_ack_no_req,
  output logic [1:0]       state_dbg
);

  localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_PRE   = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT    = '1;

  ch_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              req_start, ack_start, ack_no_req;
  logic              wait_load, wait_inc, timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // dreq/dack are level signals sampled once per edge; a request is serviced
  // when dack is seen high, and in ACK the channel holds until dack drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dreq && dack) state_d = ACK;
        else if (dreq)    state_d = REQ;
      end
      REQ: begin
        if (dack)       state_d = ACK;
        else if (!dreq) state_d = IDLE;
      end
      ACK: begin
        if (!dack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_start  = 1'b0;
    ack_start  = 1'b0;
    ack_no_req = 1'b0;
    wait_load  = 1'b0;
    wait_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_start  = dreq;
        ack_start  = dreq && dack;
        ack_no_req = !dreq && dack;
        wait_load  = dreq && !dack;
      end
      REQ: begin
        ack_start = dack;
        wait_inc  = dreq && !dack;
      end
      default: ;
    endcase
  end

  assign timeout_hit = wait_inc && (wait_q == WAIT_PRE);

  always_ff @(posedge clk) begin
    if (reset)                             wait_q <= '0;
    else if (wait_load)                    wait_q <= WAIT_W'(1);
    else if (wait_inc && wait_q != WAIT_MAX) wait_q <= wait_q + 1'b1;
    else if (!wait_inc)                    wait_q <= '0;
  end

  // clear wipes the observable results but not the protocol tracking above.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      req_count      <= '0;
      ack_count      <= '0;
      err_timeout    <= 1'b0;
      err_ack_no_req <= 1'b0;
    end else begin
      if (req_start && req_count != CNT_SAT) req_count <= req_count + 1'b1;
      if (ack_start && ack_count != CNT_SAT) ack_count <= ack_count + 1'b1;
      if (timeout_hit) err_timeout    <= 1'b1;
      if (ack_no_req)  err_ack_no_req <= 1'b1;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: rtl/dma_req_ack_monitor.sv
// Multi-channel DMA request/acknowledge protocol monitor: per-channel trackers
// plus a cross-channel multiple-acknowledge flag and a coverage indicator.
module dma_req_ack_monitor
  import dma_mon_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_CH-1:0]       DREQ,
  input  logic [NUM_CH-1:0]       DACK,
  input  logic                    clear,
  output logic [NUM_CH*CNT_W-1:0] req_count,
  output logic [NUM_CH*CNT_W-1:0] ack_count,
  output logic [NUM_CH-1:0]       err_timeout,
  output logic [NUM_CH-1:0]       err_ack_no_req,
  output logic                    err_multi_ack,
  output logic                    all_covered,
  output logic [2*NUM_CH-1:0]     ch_state
);

  logic [MAX_CH-1:0] dack_ext;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dma_mon_channel #(
      .CNT_W    (CNT_W),
      .MAX_WAIT (MAX_WAIT)
    ) u_ch (
      .clk            (CLK),
      .reset          (RESET),
      .clear          (clear),
      .dreq           (DREQ[g]),
      .dack           (DACK[g]),
      .req_count      (req_count[g*CNT_W +: CNT_W]),
      .ack_count      (ack_count[g*CNT_W +: CNT_W]),
      .err_timeout    (err_timeout[g]),
      .err_ack_no_req (err_ack_no_req[g]),
      .state_dbg      (ch_state[2*g +: 2])
    );
  end

  assign dack_ext = MAX_CH'(DACK);

  always_ff @(posedge CLK) begin
    if (RESET || clear)                  err_multi_ack <= 1'b0;
    else if (popcount8(dack_ext) >= 2)   err_multi_ack <= 1'b1;
  end

  always_comb begin
    all_covered = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_count[i*CNT_W +: CNT_W] == '0 || ack_count[i*CNT_W +: CNT_W] == '0)
        all_covered = 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_req_ack_monitor.sv
// Bench for dma_req_ack_monitor with NUM_CH=4, CNT_W=4, MAX_WAIT=8:
// table vectors, hand sequences and a random burst against a behavioural model.
module tb_dma_req_ack_monitor;

  localparam int NCH   = 4;
  localparam int CW    = 4;
  localparam int MW    = 8;
  localparam int EXP_W = 2*NCH*CW + 2*NCH + 2 + 2*NCH;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [NCH-1:0]    DREQ = '0;
  logic [NCH-1:0]    DACK = '0;
  logic              clear = 1'b0;
  logic [NCH*CW-1:0] req_count, ack_count;
  logic [NCH-1:0]    err_timeout, err_ack_no_req;
  logic              err_multi_ack, all_covered;
  logic [2*NCH-1:0]  ch_state;

  int checks = 0;
  int failures = 0;

  logic [EXP_W-1:0] exp_q[$];

  // behavioural model state (0=IDLE, 1=REQ, 2=ACK)
  int   m_st[NCH], m_wait[NCH], m_req[NCH], m_ack[NCH];
  logic [NCH-1:0] m_tmo, m_anr;
  logic m_multi;

  typedef struct {
    logic [3:0] dreq;
    logic [3:0] dack;
    logic       clr;
    logic [7:0] exp_state;
    logic [3:0] exp_tmo;
    logic [3:0] exp_anr;
    logic       exp_multi;
  } vec_t;
  vec_t vecs[$];

  dma_req_ack_monitor #(.NUM_CH(NCH), .CNT_W(CW), .MAX_WAIT(MW)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .DREQ           (DREQ),
    .DACK           (DACK),
    .clear          (clear),
    .req_count      (req_count),
    .ack_count      (ack_count),
    .err_timeout    (err_timeout),
    .err_ack_no_req (err_ack_no_req),
    .err_multi_ack  (err_multi_ack),
    .all_covered    (all_covered),
    .ch_state       (ch_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] dq, input logic [3:0] dk,
                            input logic clr, input logic rst);
    int ones;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_st[i] = 0; m_wait[i] = 0; m_req[i] = 0; m_ack[i] = 0;
      end
      m_tmo = '0; m_anr = '0; m_multi = 1'b0;
      return;
    end
    ones = 0;
    for (int i = 0; i < NCH; i++) ones += int'(dk[i]);
    for (int i = 0; i < NCH; i++) begin
      bit inc_r, inc_a, anr, tmo;
      inc_r = 0; inc_a = 0; anr = 0; tmo = 0;
      if (m_st[i] == 0) begin
        if (dq[i] && dk[i])      begin m_st[i] = 2; inc_r = 1; inc_a = 1; end
        else if (dq[i])          begin m_st[i] = 1; m_wait[i] = 1; inc_r = 1; end
        else if (dk[i])          anr = 1;
      end else if (m_st[i] == 1) begin
        if (dk[i])               begin m_st[i] = 2; inc_a = 1; end
        else if (!dq[i])         m_st[i] = 0;
        else if (m_wait[i] < MW) begin
          m_wait[i]++;
          if (m_wait[i] == MW) tmo = 1;
        end
      end else begin
        if (!dk[i]) m_st[i] = 0;
      end
      if (clr) begin
        m_req[i] = 0; m_ack[i] = 0; m_tmo[i] = 1'b0; m_anr[i] = 1'b0;
      end else begin
        if (inc_r && m_req[i] < 15) m_req[i]++;
        if (inc_a && m_ack[i] < 15) m_ack[i]++;
        if (tmo) m_tmo[i] = 1'b1;
        if (anr) m_anr[i] = 1'b1;
      end
    end
    if (clr)            m_multi = 1'b0;
    else if (ones >= 2) m_multi = 1'b1;
  endtask

  function automatic logic [EXP_W-1:0] model_pack();
    logic [NCH*CW-1:0] r, a;
    logic [2*NCH-1:0]  s;
    logic              cov;
    cov = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      r[i*CW +: CW] = CW'(m_req[i]);
      a[i*CW +: CW] = CW'(m_ack[i]);
      s[2*i +: 2]   = 2'(m_st[i]);
      if (m_req[i] == 0 || m_ack[i] == 0) cov = 1'b0;
    end
    return {r, a, m_tmo, m_anr, m_multi, cov, s};
  endfunction

  // driver: one sample of inputs, scoreboarded against the model
  task automatic cycle(input logic [3:0] dq, input logic [3:0] dk,
                       input logic clr, input logic rst);
    logic [EXP_W-1:0] e;
    @(negedge CLK);
    DREQ = dq; DACK = dk; clear = clr; RESET = rst;
    model_step(dq, dk, clr, rst);
    exp_q.push_back(model_pack());
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check("req_count",      32'(req_count),      32'(e[49:34]));
    check("ack_count",      32'(ack_count),      32'(e[33:18]));
    check("err_timeout",    32'(err_timeout),    32'(e[17:14]));
    check("err_ack_no_req", 32'(err_ack_no_req), 32'(e[13:10]));
    check("err_multi_ack",  32'(err_multi_ack),  32'(e[9]));
    check("all_covered",    32'(all_covered),    32'(e[8]));
    check("ch_state",       32'(ch_state),       32'(e[7:0]));
  endtask

  task automatic add_vec(input logic [3:0] dq, input logic [3:0] dk, input logic clr,
                         input logic [7:0] st, input logic [3:0] tmo,
                         input logic [3:0] anr, input logic multi);
    vec_t v;
    v.dreq = dq; v.dack = dk; v.clr = clr;
    v.exp_state = st; v.exp_tmo = tmo; v.exp_anr = anr; v.exp_multi = multi;
    vecs.push_back(v);
  endtask

  task automatic pair(input int ch);
    logic [3:0] m;
    m = 4'b0001 << ch;
    cycle(m, 4'b0000, 1'b0, 1'b0);
    cycle(m, m,       1'b0, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = 0; m_wait[i] = 0; m_req[i] = 0; m_ack[i] = 0;
    end
    m_tmo = '0; m_anr = '0; m_multi = 1'b0;

    // reset state
    cycle(4'h0, 4'h0, 1'b0, 1'b1);
    cycle(4'h0, 4'h0, 1'b0, 1'b1);
    check("rst_req_count", 32'(req_count), 32'd0);
    check("rst_all_covered", 32'(all_covered), 32'd0);

    // table: single transfer, timeout, ack-without-request, multi-ack, clear edge
    add_vec(4'b0001, 4'b0000, 0, 8'h01, 4'h0, 4'h0, 0);
    add_vec(4'b0001, 4'b0000, 0, 8'h01, 4'h0, 4'h0, 0);
    add_vec(4'b0001, 4'b0000, 0, 8'h01, 4'h0, 4'h0, 0);
    add_vec(4'b0001, 4'b0001, 0, 8'h02, 4'h0, 4'h0, 0);
    add_vec(4'b0001, 4'b0001, 0, 8'h02, 4'h0, 4'h0, 0);
    add_vec(4'b0000, 4'b0000, 0, 8'h00, 4'h0, 4'h0, 0);
    for (int i = 0; i < 7; i++) add_vec(4'b0100, 4'b0000, 0, 8'h10, 4'h0, 4'h0, 0);
    add_vec(4'b0100, 4'b0000, 0, 8'h10, 4'b0100, 4'h0, 0);
    add_vec(4'b0100, 4'b0000, 0, 8'h10, 4'b0100, 4'h0, 0);
    add_vec(4'b0000, 4'b0000, 0, 8'h00, 4'b0100, 4'h0, 0);
    add_vec(4'b0000, 4'b0010, 0, 8'h00, 4'b0100, 4'b0010, 0);
    add_vec(4'b0000, 4'b1010, 0, 8'h00, 4'b0100, 4'b1010, 1);
    add_vec(4'b0000, 4'b0000, 0, 8'h00, 4'b0100, 4'b1010, 1);
    add_vec(4'b0001, 4'b0001, 0, 8'h02, 4'b0100, 4'b1010, 1);
    add_vec(4'b0000, 4'b0001, 0, 8'h02, 4'b0100, 4'b1010, 1);
    add_vec(4'b0001, 4'b0000, 0, 8'h00, 4'b0100, 4'b1010, 1);
    add_vec(4'b0001, 4'b0000, 0, 8'h01, 4'b0100, 4'b1010, 1);
    add_vec(4'b0000, 4'b0000, 0, 8'h00, 4'b0100, 4'b1010, 1);
    add_vec(4'b0001, 4'b0000, 1, 8'h01, 4'h0, 4'h0, 0);
    add_vec(4'b0000, 4'b0000, 0, 8'h00, 4'h0, 4'h0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].dreq, vecs[i].dack, vecs[i].clr, 1'b0);
      check("tbl_state", 32'(ch_state),       32'(vecs[i].exp_state));
      check("tbl_tmo",   32'(err_timeout),    32'(vecs[i].exp_tmo));
      check("tbl_anr",   32'(err_ack_no_req), 32'(vecs[i].exp_anr));
      check("tbl_multi", 32'(err_multi_ack),  32'(vecs[i].exp_multi));
      if (i == 5) begin
        check("xfer_req0", 32'(req_count[3:0]), 32'd1);
        check("xfer_ack0", 32'(ack_count[3:0]), 32'd1);
      end
      if (i == 13) check("tmo_req2", 32'(req_count[11:8]), 32'd1);
      if (i == 24) check("clr_edge_req0", 32'(req_count[3:0]), 32'd0);
    end

    // saturation, coverage and clear
    for (int k = 0; k < 20; k++) pair(3);
    check("sat_req3", 32'(req_count[15:12]), 32'hF);
    check("sat_ack3", 32'(ack_count[15:12]), 32'hF);
    check("cov_before", 32'(all_covered), 32'd0);
    for (int c = 0; c < 3; c++) pair(c);
    check("cov_after", 32'(all_covered), 32'd1);
    cycle(4'h0, 4'h0, 1'b1, 1'b0);
    check("clr_req", 32'(req_count), 32'd0);
    check("clr_ack", 32'(ack_count), 32'd0);
    check("clr_cov", 32'(all_covered), 32'd0);

    // reset in the middle of a transfer
    cycle(4'b0001, 4'b0001, 1'b0, 1'b0);
    check("pre_rst_state", 32'(ch_state), 32'h02);
    cycle(4'b0001, 4'b0001, 1'b0, 1'b1);
    check("mid_rst_state", 32'(ch_state), 32'h00);
    check("mid_rst_anr", 32'(err_ack_no_req), 32'd0);
    check("mid_rst_ack", 32'(ack_count), 32'd0);
    cycle(4'b0000, 4'b0001, 1'b0, 1'b0);
    check("post_rst_anr", 32'(err_ack_no_req), 32'b0001);

    // random burst
    for (int k = 0; k < 300; k++) begin
      logic [3:0] dq, dk;
      dq = 4'($urandom_range(0, 15));
      dk = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      cycle(dq, dk, $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
